// File: rtl/prefix_channel_queue_if.sv
// ---------------------------------------------------------------------------
// prefix_channel_queue_if
//
// Valid/ready channel bundle for prefix_channel_queue. Carries both the
// upstream (in_*) and downstream (out_*) handshakes of the queue, so one
// instance describes everything that flows through the block.
//
// Parameters:
//   DATA_W     width of one data lane
//   NUM_LANES  lanes per beat; a beat is DATA_W*NUM_LANES bits, and lane i
//              occupies bits [i*DATA_W +: DATA_W]
//
// Modports:
//   master  the stimulus / consumer side (drives in_valid, in_bits_data,
//           out_ready)
//   slave   the queue itself (drives in_ready, out_valid, out_bits_data)
// ---------------------------------------------------------------------------
interface prefix_channel_queue_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 3
);

  localparam int BEAT_W = DATA_W * NUM_LANES;

  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_bits_data;

  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_bits_data;

  modport master (
    output in_valid,
    output in_bits_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bits_data
  );

  modport slave (
    input  in_valid,
    input  in_bits_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bits_data
  );

endinterface : prefix_channel_queue_if

// File: rtl/prefix_channel_queue.sv
// ---------------------------------------------------------------------------
// prefix_channel_queue
//
// Buffering receiver for a multi-lane valid/ready channel. Beats of
// NUM_LANES lanes (DATA_W bits each) are written into a DEPTH-entry FIFO
// and re-presented on the downstream side of the same channel bundle.
// Upstream acceptance can be throttled by a 4-bit stall mask that is
// indexed by a free-running 2-bit phase counter.
//
// Ports:
//   clock          posedge clock for all state
//   reset          synchronous, active-high; clears pointers, occupancy,
//                  counters and phase (storage contents are left as-is)
//   stall_pattern  stall_pattern[phase] = 1 blocks acceptance this cycle
//   chan           channel bundle (slave side):
//                    in_valid / in_ready / in_bits_data     upstream beat
//                    out_valid / out_ready / out_bits_data  head entry
//   lane_sum       unsigned sum of the lanes of out_bits_data
//   occupancy      number of stored entries, 0..DEPTH
//   accept_count   number of accepted beats, wraps modulo 2^CNT_W
//
// Behaviour summary:
//   - in_ready depends only on registered state and stall_pattern; a full
//     queue never accepts, even when the head is leaving the same cycle.
//   - No bypass: a beat written into an empty queue is visible on out_*
//     one cycle later.
//   - While empty, out_bits_data and lane_sum are driven to zero.
// ---------------------------------------------------------------------------
module prefix_channel_queue #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_LANES = 3,
  parameter  int DEPTH     = 4,
  parameter  int CNT_W     = 32,
  localparam int BEAT_W    = DATA_W * NUM_LANES,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int SUM_W     = DATA_W + $clog2(NUM_LANES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           stall_pattern,
  prefix_channel_queue_if.slave chan,
  output logic [SUM_W-1:0]     lane_sum,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     accept_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [BEAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        phase;

  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;
  logic [BEAT_W-1:0] head;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  assign full  = (occupancy == OCC_W'(DEPTH));
  assign empty = (occupancy == '0);

  // Acceptance is decided from registered state only, so in_ready never
  // forms a combinational path from in_valid or out_ready.
  assign chan.in_ready  = !full && !stall_pattern[phase];
  assign chan.out_valid = !empty;

  assign enq = chan.in_valid  && chan.in_ready;
  assign deq = chan.out_valid && chan.out_ready;

  // -------------------------------------------------------------------------
  // Control registers: pointers, occupancy, accept counter, phase
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      accept_count <= '0;
      phase        <= '0;
    end else begin
      phase <= phase + 2'd1;

      if (enq) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        accept_count <= accept_count + CNT_W'(1);
      end

      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      // Simultaneous enqueue and dequeue leaves the count unchanged.
      unique case ({enq, deq})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the entry array has no reset; stale contents are never observable
  // because out_* is masked whenever the queue is empty, and leaving it
  // unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      mem[wr_ptr] <= chan.in_bits_data;
    end
  end

  // -------------------------------------------------------------------------
  // Head presentation and lane checksum
  // -------------------------------------------------------------------------
  assign head               = empty ? '0 : mem[rd_ptr];
  assign chan.out_bits_data = head;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a value before any conditional logic, so no latch is inferred.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      // Lanes are zero-extended to SUM_W first, so the sum cannot overflow.
      lane_sum = lane_sum + SUM_W'(head[i*DATA_W +: DATA_W]);
    end
  end

endmodule : prefix_channel_queue

// File: tb/tb_prefix_channel_queue.sv
// ---------------------------------------------------------------------------
// tb_prefix_channel_queue
//
// Self-checking bench for prefix_channel_queue. A reference model (a queue
// of expected beats plus occupancy / count / phase bookkeeping) is updated
// from observed handshakes; a separate monitor compares every presented
// head beat and its lane checksum against the front of that queue.
// ---------------------------------------------------------------------------
module tb_prefix_channel_queue;

  localparam int DATA_W    = 8;
  localparam int NUM_LANES = 3;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 32;
  localparam int BEAT_W    = DATA_W * NUM_LANES;
  localparam int OCC_W     = $clog2(DEPTH + 1);
  localparam int SUM_W     = DATA_W + $clog2(NUM_LANES);

  logic               clock;
  logic               reset;
  logic [3:0]         stall_pattern;
  logic [SUM_W-1:0]   lane_sum;
  logic [OCC_W-1:0]   occupancy;
  logic [CNT_W-1:0]   accept_count;

  prefix_channel_queue_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) chan ();

  prefix_channel_queue #(
    .DATA_W   (DATA_W),
    .NUM_LANES(NUM_LANES),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall_pattern(stall_pattern),
    .chan         (chan),
    .lane_sum     (lane_sum),
    .occupancy    (occupancy),
    .accept_count (accept_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [BEAT_W-1:0] exp_q [$];
  int                model_occ   = 0;
  logic [CNT_W-1:0]  model_cnt   = '0;
  int                model_phase = 0;
  bit                model_live  = 1'b0;
  bit                enq_f       = 1'b0;
  bit                deq_f       = 1'b0;

  function automatic int ref_sum(input logic [BEAT_W-1:0] beat);
    int s = 0;
    for (int i = 0; i < NUM_LANES; i++) s += int'(beat[i*DATA_W +: DATA_W]);
    return s;
  endfunction

  // Observe handshakes mid-cycle; record accepted beats as expectations.
  always @(negedge clock) begin : sample_in
    if (model_live) begin
      check("occupancy",    64'(occupancy),    64'(model_occ));
      check("accept_count", 64'(accept_count), 64'(model_cnt));
      check("in_ready",     64'(chan.in_ready),
            64'((model_occ != DEPTH) && !stall_pattern[model_phase]));
      check("out_valid",    64'(chan.out_valid), 64'(model_occ != 0));
      enq_f = !reset && chan.in_valid  && chan.in_ready;
      deq_f = !reset && chan.out_valid && chan.out_ready;
      if (enq_f) exp_q.push_back(chan.in_bits_data);
    end
  end

  // Monitor: compare the presented head against the scoreboard.
  always @(negedge clock) begin : monitor_out
    if (model_live) begin
      if (chan.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(chan.out_bits_data), 64'hDEAD_0000_0000_0000);
        end else begin
          check("out_data", 64'(chan.out_bits_data), 64'(exp_q[0]));
          check("lane_sum", 64'(lane_sum),           64'(ref_sum(exp_q[0])));
          if (chan.out_ready && !reset) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_data", 64'(chan.out_bits_data), 64'd0);
        check("idle_sum",  64'(lane_sum),           64'd0);
      end
    end
  end

  // Advance the model at the clock edge using the handshakes seen mid-cycle.
  always @(posedge clock) begin : model_step
    if (reset) begin
      model_live  <= 1'b1;
      model_occ   <= 0;
      model_cnt   <= '0;
      model_phase <= 0;
      exp_q.delete();
    end else if (model_live) begin
      model_occ   <= model_occ + int'(enq_f) - int'(deq_f);
      if (enq_f) model_cnt <= model_cnt + CNT_W'(1);
      model_phase <= (model_phase + 1) % 4;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Present one beat and hold it until it is accepted.
  task automatic push_beat(input logic [BEAT_W-1:0] d);
    chan.in_valid     = 1'b1;
    chan.in_bits_data = d;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (chan.in_ready) begin
        sync();
        chan.in_valid = 1'b0;
        return;
      end
      sync();
    end
    timeout_fail("push_beat");
    chan.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (occupancy == '0) begin
        sync();
        return;
      end
      sync();
    end
    timeout_fail("wait_empty");
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt0;
  logic [BEAT_W-1:0] rnd_data;
  bit                acc;

  initial begin
    reset             = 1'b1;
    stall_pattern     = 4'b0000;
    chan.in_valid     = 1'b0;
    chan.in_bits_data = '0;
    chan.out_ready    = 1'b0;

    // Reset and idle.
    sync();
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("reset_in_ready",  64'(chan.in_ready),  64'd1);
    check("reset_out_valid", 64'(chan.out_valid), 64'd0);
    check("reset_occupancy", 64'(occupancy),      64'd0);
    check("reset_count",     64'(accept_count),   64'd0);
    sync();

    // Single beat: lanes {0x01, 0x02, 0xFF}.
    push_beat(24'hFF0201);
    @(negedge clock);
    check("single_data",  64'(chan.out_bits_data), 64'hFF0201);
    check("single_sum",   64'(lane_sum),           64'd258);
    check("single_occ",   64'(occupancy),          64'd1);
    check("single_count", 64'(accept_count),       64'd1);
    sync();
    chan.out_ready = 1'b1;
    sync();
    chan.out_ready = 1'b0;
    @(negedge clock);
    check("single_drained", 64'(chan.out_valid), 64'd0);
    sync();

    // Fill to DEPTH, verify no acceptance when full even with a dequeue.
    for (int i = 0; i < DEPTH; i++) push_beat(BEAT_W'(24'hA00000 + i));
    chan.in_valid     = 1'b1;
    chan.in_bits_data = 24'hEEEEEE;
    chan.out_ready    = 1'b1;
    @(negedge clock);
    check("full_occ",      64'(occupancy),     64'(DEPTH));
    check("full_in_ready", 64'(chan.in_ready), 64'd0);
    sync();
    chan.in_valid = 1'b0;
    sync();
    chan.out_ready = 1'b0;
    // Two drained; add three across the pointer wrap.
    push_beat(24'hB00000);
    push_beat(24'hB00001);
    chan.out_ready = 1'b1;
    push_beat(24'hB00002);
    wait_empty();
    @(negedge clock);
    check("fill_count", 64'(accept_count), 64'd8);
    sync();

    // Backpressure: stall phases 0 and 2, in_valid held high.
    stall_pattern     = 4'b0101;
    chan.out_ready    = 1'b1;
    chan.in_valid     = 1'b1;
    chan.in_bits_data = 24'hC00000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 0) cnt0 = accept_count;
      acc = chan.in_ready;
      sync();
      if (acc) chan.in_bits_data = chan.in_bits_data + BEAT_W'(1);
    end
    @(negedge clock);
    check("stall_rate", 64'(accept_count - cnt0), 64'd4);
    sync();
    chan.in_valid = 1'b0;
    stall_pattern = 4'b0000;
    wait_empty();

    // Streaming: one beat per cycle, occupancy settles at 1.
    chan.out_ready = 1'b1;
    chan.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chan.in_bits_data = BEAT_W'(i);
      @(negedge clock);
      if (i > 0) check("stream_occ", 64'(occupancy), 64'd1);
      sync();
    end
    chan.in_valid = 1'b0;
    wait_empty();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      acc = chan.in_valid && chan.in_ready;
      sync();
      if (acc || !chan.in_valid) begin
        rnd_data          = BEAT_W'($urandom);
        chan.in_valid     = ($urandom_range(0, 3) != 0);
        chan.in_bits_data = rnd_data;
      end
      chan.out_ready = 1'($urandom_range(0, 1));
      if (c % 32 == 0) stall_pattern = 4'($urandom_range(0, 15));
    end
    chan.in_valid  = 1'b0;
    chan.out_ready = 1'b1;
    stall_pattern  = 4'b0000;
    wait_empty();

    // Reset mid-stream with three entries stored.
    chan.out_ready = 1'b0;
    push_beat(24'h111111);
    push_beat(24'h222222);
    push_beat(24'h333333);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_occ",   64'(occupancy),      64'd0);
    check("mid_reset_valid", 64'(chan.out_valid), 64'd0);
    check("mid_reset_count", 64'(accept_count),   64'd0);
    sync();
    push_beat(24'h030201);
    @(negedge clock);
    check("post_reset_data", 64'(chan.out_bits_data), 64'h030201);
    check("post_reset_sum",  64'(lane_sum),           64'd6);
    sync();
    chan.out_ready = 1'b1;
    wait_empty();

    @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_prefix_channel_queue
